booth_mult_seq_4: RTL and testbench

- Iterative signed radix-4 Booth multiplier sequencer for the FFT butterfly twiddle multiply path.
- Captures a multiplicand/multiplier pair on a start handshake.
- Walks the multiplier in overlapping 3-bit Booth windows, LSB first, and adds one weighted partial product per clock into a 2*WIDTH accumulator.
- Presents the exact signed product with a one-cycle done pulse.
- Sits upstream of the butterfly add/sub stage and consumes twiddle/sample operands from the stage controller.

---
 rtl/booth_mult_seq_4_pkg.sv | 42 ++++
 rtl/booth_mult_seq_4_pp_sel.sv | 47 ++++
 rtl/booth_mult_seq_4.sv | 126 ++++++++++++
 tb/tb_booth_mult_seq_4.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_seq_4_pkg.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_4_pkg
// Shared definitions for the iterative radix-4 Booth multiplier:
//   - sequencer state encoding
//   - named Booth window encodings {b[2i+1], b[2i], b[2i-1]}
//   - default operand width and helpers for the derived sizes
// -----------------------------------------------------------------------------
package booth_mult_seq_4_pkg;

    localparam int DEF_WIDTH = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Booth windows, named by the digit each one selects.
    localparam logic [2:0] WIN_ZERO_LO = 3'b000;  //  0
    localparam logic [2:0] WIN_POS1_A  = 3'b001;  // +1
    localparam logic [2:0] WIN_POS1_B  = 3'b010;  // +1
    localparam logic [2:0] WIN_POS2    = 3'b011;  // +2
    localparam logic [2:0] WIN_NEG2    = 3'b100;  // -2
    localparam logic [2:0] WIN_NEG1_A  = 3'b101;  // -1
    localparam logic [2:0] WIN_NEG1_B  = 3'b110;  // -1
    localparam logic [2:0] WIN_ZERO_HI = 3'b111;  //  0

    // Product width for a given operand width.
    function automatic int pw_of(input int width);
        return 2 * width;
    endfunction

    // Number of Booth steps (two multiplier bits per step).
    function automatic int steps_of(input int width);
        return width / 2;
    endfunction

    // Width of the step index; never below one bit.
    function automatic int idx_w_of(input int width);
        return (width / 2 <= 2) ? 1 : $clog2(width / 2);
    endfunction

endpackage

// File: rtl/booth_mult_seq_4_pp_sel.sv
// -----------------------------------------------------------------------------
// booth_pp_sel_4
// Combinational partial-product selector for one radix-4 Booth step.
// Ports:
//   window  in   3        Booth window {b[2i+1], b[2i], b[2i-1]}
//   a       in   WIDTH    signed multiplicand
//   idx     in   IDX_W    step index i
//   pp      out  2*WIDTH  sign-extended A * digit, shifted left by 2i
// -----------------------------------------------------------------------------
module booth_pp_sel_4
    import booth_mult_seq_4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_w_of(DEF_WIDTH)
) (
    input  logic [2:0]             window,
    input  logic [WIDTH-1:0]       a,
    input  logic [IDX_W-1:0]       idx,
    output logic [2*WIDTH-1:0]     pp
);

    localparam int PW = pw_of(WIDTH);

    logic [PW-1:0] a_ext;
    logic [PW-1:0] mag;

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

    // Negation is done at full product width so the sign extension of -A
    // (and of -2A) is exact, including for the most negative A.
    always_comb begin
        // NOTE: default first so every path assigns mag and no latch is inferred.
        mag = '0;
        case (window)
            WIN_ZERO_LO, WIN_ZERO_HI: mag = '0;
            WIN_POS1_A,  WIN_POS1_B:  mag = a_ext;
            WIN_POS2:                 mag = a_ext << 1;
            WIN_NEG2:                 mag = ~(a_ext << 1) + PW'(1);
            WIN_NEG1_A,  WIN_NEG1_B:  mag = ~a_ext + PW'(1);
            default:                  mag = '0;
        endcase
    end

    // Weight 4^i is a left shift by 2i.
    assign pp = mag << {idx, 1'b0};

endmodule

// File: rtl/booth_mult_seq_4.sv
// -----------------------------------------------------------------------------
// booth_mult_seq_4
// Iterative signed radix-4 Booth multiplier. Captures A/B on start in IDLE,
// adds one weighted partial product per clock for WIDTH/2 clocks, then writes
// the exact 2*WIDTH signed product and pulses done for one cycle.
// Ports:
//   clk      in   1        system clock
//   rst      in   1        asynchronous active-high reset
//   start    in   1        request; sampled only in IDLE
//   mult_a   in   WIDTH    signed multiplicand
//   mult_b   in   WIDTH    signed multiplier
//   busy     out  1        multiplication in progress
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  signed product, held until the next done
// -----------------------------------------------------------------------------
module booth_mult_seq_4
    import booth_mult_seq_4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mult_a,
    input  logic [WIDTH-1:0]     mult_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = pw_of(WIDTH);
    localparam int STEPS = steps_of(WIDTH);
    localparam int IDX_W = idx_w_of(WIDTH);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [PW-1:0]     acc;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        window;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_next;
    logic              last_step;

    // B with the implicit B[-1]=0 appended below the LSB, so window i is
    // simply bits [2i+2 : 2i] of this vector.
    logic [WIDTH:0]    b_ext;
    assign b_ext     = {b_reg, 1'b0};
    assign window    = 3'(b_ext >> {idx, 1'b0});
    assign last_step = (idx == IDX_W'(STEPS - 1));
    assign acc_next  = acc + pp;

    booth_pp_sel_4 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pp_sel (
        .window (window),
        .a      (a_reg),
        .idx    (idx),
        .pp     (pp)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = RUN;
            RUN:     if (last_step) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath: operand capture, accumulation and result write-back.
    // The final step writes acc + pp straight to product so the result is
    // available on the same edge that ends RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: all datapath registers are reset so an abandoned
            // operation leaves product reading zero.
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            idx     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= mult_a;
                        b_reg <= mult_b;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                    if (last_step) begin
                        product <= acc_next;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq_4.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq_4
// Directed and randomized checks of booth_mult_seq_4 at WIDTH=12 against a
// plain signed-multiply reference.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq_4;

    localparam int W  = 12;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  mult_a;
    logic [W-1:0]  mult_b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int vectors;
    int miscompares;

    booth_mult_seq_4 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mult_a  (mult_a),
        .mult_b  (mult_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: exact signed product, reduced to PW bits.
    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return PW'(pa * pb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait up to 'limit' edges for done; returns edges waited and busy-high samples.
    task automatic wait_done(input int limit, output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (edges < limit) begin
            @(posedge clk); #1;
            edges++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    // Full multiply from IDLE; caller is 1 time unit after an edge.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int edges;
        int busy_cnt;
        logic [PW-1:0] exp;
        exp    = model(a, b);
        mult_a = a;
        mult_b = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        check({tag, " busy_after_capture"}, 64'(busy), 64'd1);
        // Operands may change freely once captured.
        mult_a = W'($urandom);
        mult_b = W'($urandom);
        wait_done(20, edges, busy_cnt);
        check({tag, " latency"}, 64'(edges), 64'd6);
        check({tag, " product"}, 64'(product), 64'(exp));
        check({tag, " busy_cycles"}, 64'(busy_cnt + 1), 64'd6);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        check({tag, " product_held"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int edges;
        int busy_cnt;
        int done_seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start  = 1'b0;
        mult_a = '0;
        mult_b = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", 64'(product), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed products.
        do_mult(12'd3, 12'd5, "3x5");
        check("3x5 const", 64'(product), 64'h00000F);
        do_mult(12'h800, 12'h800, "min_x_min");
        check("min_x_min const", 64'(product), 64'h400000);
        do_mult(12'h7FF, 12'h800, "max_x_min");
        check("max_x_min const", 64'(product), 64'hC00800);
        do_mult(12'hFFF, 12'hFFF, "m1_x_m1");
        do_mult(12'h7FF, 12'h000, "max_x_0");
        do_mult(12'hFF9, 12'h555, "m7_x_555");
        check("m7_x_555 const", 64'(product), 64'hFFDAAD);
        do_mult(12'hFF9, 12'hAAA, "m7_x_AAA");
        check("m7_x_AAA const", 64'(product), 64'h00255A);

        // start while busy is ignored.
        mult_a = 12'd3;
        mult_b = 12'd5;
        start  = 1'b1;
        @(posedge clk); #1;              // capture edge
        start = 1'b0;
        @(posedge clk); #1;              // RUN cycle 2
        mult_a = 12'd9;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;                   // RUN cycle 3
        @(posedge clk); #1;              // RUN cycle 4
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(20, edges, busy_cnt);
        check("busy_start latency", 64'(edges + 4), 64'd6);
        check("busy_start product", 64'(product), 64'd15);

        // Back-to-back: start presented during the done cycle.
        mult_a = 12'd6;
        mult_b = 12'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(20, edges, busy_cnt);
        check("b2b done_spacing", 64'(edges + 1), 64'd7);
        check("b2b product", 64'(product), 64'd42);
        @(posedge clk); #1;

        // Reset mid-operation: async, takes effect without a clock edge.
        mult_a = 12'd100;
        mult_b = 12'd100;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst product", 64'(product), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("midrst no_done", 64'(done_seen), 64'd0);
        do_mult(12'd2, 12'hFFD, "2_x_m3");
        check("2_x_m3 const", 64'(product), 64'hFFFFFA);

        // Randomized operands.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_mult(ra, rb, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
